// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
//   Shared constants and types for the Basys3 seven-segment display driver:
//   the blank segment pattern, the all-anodes-off pattern, the active-low
//   hex glyph table and the display word captured on a load strobe.
package seven_seg_pkg;

    // All segments dark ({g,f,e,d,c,b,a}, active-low)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All anodes disabled (active-low)
    localparam logic [3:0] ANODE_OFF = 4'hF;

    // Active-low glyphs for 0..F, indexed by nibble value
    localparam logic [6:0] HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Everything that must change atomically at a frame boundary
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        lz;
    } disp_word_t;

endpackage

// File: rtl/seven_seg_driver_hex_to_seg.sv
// hex_to_seg
//   Combinational nibble-to-glyph lookup.
//   hex_i : 4-bit digit value
//   seg_o : {g,f,e,d,c,b,a}, active-low
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = HEX_SEG_TABLE[hex_i];
    end

endmodule

// File: rtl/seven_seg_driver.sv
// seven_seg_driver
//   Drives a 4-digit multiplexed seven-segment display from a 16-bit hex word.
//   A display word is latched on `load` and only becomes visible at the next
//   frame boundary, so a frame never mixes old and new digits. Each digit slot
//   is PWM-dimmed by `brightness`; leading-zero blanking, per-digit blanking and
//   decimal points are supported.
//
//   clk, rst    : clock, synchronous active-high reset
//   value       : four hex digits, [3:0] is digit 0 (rightmost, an[0])
//   dp_in       : per-digit decimal point enable (1 = lit)
//   blank_in    : per-digit force dark (1 = dark)
//   lz_blank    : enable leading-zero blanking
//   brightness  : 0 = dimmest, 15 = full on
//   load        : one-cycle strobe capturing value/dp_in/blank_in/lz_blank
//   seg, dp, an : registered, active-low display pins
//   frame_done  : high on the last cycle of the digit-3 slot
module seven_seg_driver
    import seven_seg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_in,
    input  logic        lz_blank,
    input  logic [3:0]  brightness,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int SLOT   = CLK_HZ / (REFRESH_HZ * 4);
    localparam int CNT_W  = $clog2(SLOT);
    // Wide enough for (bright+1)*SLOT, which is at most 16*SLOT
    localparam int PROD_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT - 1);

    if (SLOT < 16) begin : g_slot_check
        $error("seven_seg_driver: SLOT must be at least 16");
    end

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       digit_q, digit_d;
    disp_word_t       pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    disp_word_t       active_q, active_d;
    logic [3:0]       bright_q, bright_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic [3:0]       an_q, an_d;

    disp_word_t       in_word;
    logic             boundary;
    logic [3:0]       nibble;
    logic [6:0]       glyph;
    logic             lz_dark;
    logic             dark;
    logic [PROD_W-1:0] on_cycles;
    logic [PROD_W-1:0] slot_ext;

    assign in_word = {value, dp_in, blank_in, lz_blank};

    hex_to_seg u_hex_to_seg (
        .hex_i (nibble),
        .seg_o (glyph)
    );

    // Slot/digit scan and frame-synchronous word update
    always_comb begin
        slot_cnt_d      = slot_cnt_q + CNT_W'(1);
        digit_d         = digit_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        active_d        = active_q;
        boundary        = (slot_cnt_q == SLOT_LAST) && (digit_q == 2'd3);

        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end

        if (boundary) begin
            // A load landing on the boundary itself goes straight to the
            // active word; anything still pending is superseded.
            pending_valid_d = 1'b0;
            if (load) begin
                active_d = in_word;
            end else if (pending_valid_q) begin
                active_d = pending_q;
            end
        end else if (load) begin
            pending_d       = in_word;
            pending_valid_d = 1'b1;
        end

        // Brightness is picked up once per digit slot, not per frame
        bright_d = (slot_cnt_q == '0) ? brightness : bright_q;
    end

    // Per-digit glyph, blanking and PWM
    always_comb begin
        nibble = active_q.value[{digit_q, 2'b00} +: 4];

        // Digit k is a leading zero when nibbles k..3 are all zero
        lz_dark = 1'b0;
        if (active_q.lz) begin
            unique case (digit_q)
                2'd3:    lz_dark = (active_q.value[15:12] == 4'h0);
                2'd2:    lz_dark = (active_q.value[15:8]  == 8'h00);
                2'd1:    lz_dark = (active_q.value[15:4]  == 12'h000);
                default: lz_dark = 1'b0;
            endcase
        end
        dark = active_q.blank[digit_q] | lz_dark;

        on_cycles = ((PROD_W'(bright_q) + PROD_W'(1)) * PROD_W'(SLOT)) >> 4;
        slot_ext  = PROD_W'(slot_cnt_q);

        seg_d = dark ? SEG_BLANK : glyph;
        dp_d  = dark ? 1'b1 : ~active_q.dp[digit_q];
        // Dark digits still follow PWM timing on their anode
        an_d  = (slot_ext < on_cycles) ? ~(4'b0001 << digit_q) : ANODE_OFF;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q      <= '0;
            digit_q         <= 2'd0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            bright_q        <= 4'd0;
            seg_q           <= SEG_BLANK;
            dp_q            <= 1'b1;
            an_q            <= ANODE_OFF;
        end else begin
            slot_cnt_q      <= slot_cnt_d;
            digit_q         <= digit_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            active_q        <= active_d;
            bright_q        <= bright_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
            an_q            <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = boundary;

endmodule

// File: tb/tb_seven_seg_driver.sv
module tb_seven_seg_driver;

    localparam int CLK_HZ     = 640;
    localparam int REFRESH_HZ = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic        load;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_driver #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .lz_blank   (lz_blank),
        .brightness (brightness),
        .load       (load),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    // Expected appearance of one whole displayed frame
    typedef struct packed {
        logic [27:0] seg;  // digit k at [k*7 +: 7]
        logic [3:0]  dp;   // digit k at [k]
        logic [19:0] on;   // anode-low cycles of digit k at [k*5 +: 5]
    } frame_exp_t;

    frame_exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic frame_exp_t mk(input logic [6:0] s3, input logic [6:0] s2,
                                      input logic [6:0] s1, input logic [6:0] s0,
                                      input logic [3:0] dpv, input int onc);
        frame_exp_t e;
        e.seg = {s3, s2, s1, s0};
        e.dp  = dpv;
        e.on  = {4{5'(onc)}};
        return e;
    endfunction

    // ---------------- monitor ----------------
    logic [6:0] h_seg [64];
    logic       h_dp  [64];
    logic [3:0] h_an  [64];
    logic       prev_fd = 1'b0;
    logic       gap_valid = 1'b0;
    int         gap = 0;

    task automatic eval_frame();
        frame_exp_t e;
        logic [3:0] sel;
        int cnt;
        logic ok;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_expectation: actual=none required=queued entry");
            return;
        end
        e = exp_q.pop_front();
        for (int k = 0; k < 4; k++) begin
            sel = 4'b0001 << k;
            sel = ~sel;
            cnt = 0;
            ok  = 1'b1;
            for (int j = k * 16; j < k * 16 + 16; j++) begin
                if (h_an[j] == sel) cnt++;
                else if (h_an[j] != 4'hF) ok = 1'b0;
                if (h_seg[j] != h_seg[k * 16] || h_dp[j] != h_dp[k * 16]) ok = 1'b0;
            end
            check($sformatf("seg_d%0d", k), 32'(h_seg[k * 16]), 32'(e.seg[k * 7 +: 7]));
            check($sformatf("dp_d%0d", k), 32'(h_dp[k * 16]), 32'(e.dp[k]));
            check($sformatf("on_d%0d", k), 32'(cnt), 32'(e.on[k * 5 +: 5]));
            check($sformatf("slot_clean_d%0d", k), 32'(ok), 32'd1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 63; i++) begin
                h_seg[i] = h_seg[i + 1];
                h_dp[i]  = h_dp[i + 1];
                h_an[i]  = h_an[i + 1];
            end
            h_seg[63] = seg;
            h_dp[63]  = dp;
            h_an[63]  = an;
            // The displayed frame ends one cycle after frame_done
            if (prev_fd) eval_frame();
            gap++;
            if (rst) begin
                gap_valid = 1'b0;
            end else if (frame_done) begin
                if (gap_valid) check("frame_done_period", 32'(gap), 32'd64);
                gap       = 0;
                gap_valid = 1'b1;
            end
            prev_fd = frame_done & ~rst;
        end
    end

    // ---------------- stimulus ----------------
    task automatic finish_now();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 200);
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL frame_done_timeout: actual=0 required=1");
            finish_now();
        end
    endtask

    task automatic load_word(input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] b, input logic lz);
        value    = v;
        dp_in    = d;
        blank_in = b;
        lz_blank = lz;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"}, 32'(dp), 32'd1);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        frame_exp_t z16, a16;
        z16 = mk(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, 16);
        a16 = mk(7'h79, 7'h24, 7'h08, 7'h0E, 4'hF, 16);

        rst        = 1'b1;
        load       = 1'b0;
        value      = 16'h0000;
        dp_in      = 4'h0;
        blank_in   = 4'h0;
        lz_blank   = 1'b0;
        brightness = 4'd15;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Idle after reset: zeros everywhere
        exp_q.push_back(z16);
        wait_fd();

        // Mid-frame load holds old digits until the boundary
        exp_q.push_back(z16);
        repeat (10) @(negedge clk);
        load_word(16'h12AF, 4'h0, 4'h0, 1'b0);
        wait_fd();

        exp_q.push_back(a16);
        wait_fd();
        brightness = 4'd7;

        exp_q.push_back(mk(7'h79, 7'h24, 7'h08, 7'h0E, 4'hF, 8));
        wait_fd();
        brightness = 4'd0;

        exp_q.push_back(mk(7'h79, 7'h24, 7'h08, 7'h0E, 4'hF, 1));
        wait_fd();
        brightness = 4'd15;

        // Leading-zero blanking
        exp_q.push_back(a16);
        repeat (5) @(negedge clk);
        load_word(16'h0050, 4'h0, 4'h0, 1'b1);
        wait_fd();

        exp_q.push_back(mk(7'h7F, 7'h7F, 7'h12, 7'h40, 4'hF, 16));
        repeat (5) @(negedge clk);
        load_word(16'h0000, 4'h0, 4'h0, 1'b1);
        wait_fd();

        // Decimal point on digit 2, digit 0 forced dark
        exp_q.push_back(mk(7'h7F, 7'h7F, 7'h7F, 7'h40, 4'hF, 16));
        repeat (5) @(negedge clk);
        load_word(16'h3456, 4'b0100, 4'b0001, 1'b0);
        wait_fd();

        // Two loads in one frame: the last wins
        exp_q.push_back(mk(7'h30, 7'h19, 7'h12, 7'h7F, 4'b1011, 16));
        repeat (5) @(negedge clk);
        load_word(16'h1111, 4'h0, 4'h0, 1'b0);
        repeat (5) @(negedge clk);
        load_word(16'h2222, 4'h0, 4'h0, 1'b0);
        wait_fd();

        // Pending load superseded by a load on the boundary cycle
        exp_q.push_back(mk(7'h24, 7'h24, 7'h24, 7'h24, 4'hF, 16));
        repeat (5) @(negedge clk);
        load_word(16'h7777, 4'h0, 4'h0, 1'b0);
        wait_fd();
        load_word(16'hBCDE, 4'h0, 4'h0, 1'b0);

        exp_q.push_back(mk(7'h03, 7'h46, 7'h21, 7'h06, 4'hF, 16));
        wait_fd();

        exp_q.push_back(mk(7'h03, 7'h46, 7'h21, 7'h06, 4'hF, 16));
        wait_fd();

        // Reset mid-frame discards the pending load
        repeat (5) @(negedge clk);
        load_word(16'h5555, 4'h0, 4'h0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        rst = 1'b0;

        exp_q.push_back(z16);
        wait_fd();
        exp_q.push_back(z16);
        wait_fd();
        repeat (2) @(negedge clk);
        check("frames_left_unchecked", 32'(exp_q.size()), 32'd0);

        finish_now();
    end

endmodule
